// File: rtl/kb_led_ctrl.sv
// PS/2 "Set LEDs" sequencer: sends 0xED + argument, handles ACK/resend/timeout, forwards other rx bytes.
// Optional KB_LED_AUTO_EN: decode lock-key make codes from the forwarded stream and auto-update LEDs.
module kb_led_ctrl #(
  parameter int TIMEOUT_CYC = 2500000,
  parameter int MAX_RETRY   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       led_req,
  input  logic [2:0] led_val,
  output logic       busy,
  output logic       done_tick,
  output logic       err_tick,
  output logic [2:0] led_state,
  input  logic       tx_idle,
  output logic       tx_wr,
  output logic [7:0] tx_din,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_data,
  output logic       fwd_tick,
  output logic [7:0] fwd_data
);
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {IDLE, SEND_CMD, WAIT_ACK1, SEND_ARG, WAIT_ACK2, DONE, ERR} state_t;

  state_t          state_q, state_d;
  logic [2:0]      arg_q, arg_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            busy_q, busy_d;
  logic            done_tick_q, done_tick_d;
  logic            err_tick_q, err_tick_d;
  logic [2:0]      led_state_q, led_state_d;
  logic            tx_wr_q, tx_wr_d;
  logic [7:0]      tx_din_q, tx_din_d;
  logic            fwd_tick_q, fwd_tick_d;
  logic [7:0]      fwd_data_q, fwd_data_d;
`ifdef KB_LED_AUTO_EN
  logic            brk_q, brk_d;
  logic [2:0]      shadow_q, shadow_d;
  logic            auto_pend_q, auto_pend_d;
`endif

  logic in_txn, is_ack, is_rsd, fwd;
  assign is_ack = (rx_data == 8'hFA);
  assign is_rsd = (rx_data == 8'hFE);
  assign in_txn = (state_q == SEND_CMD) || (state_q == WAIT_ACK1) ||
                  (state_q == SEND_ARG) || (state_q == WAIT_ACK2);
  // ACK/resend bytes are only swallowed while a transaction owns them
  assign fwd = rx_done_tick && !(in_txn && (is_ack || is_rsd));

  always_comb begin
    state_d     = state_q;
    arg_d       = arg_q;
    retry_d     = retry_q;
    timer_d     = timer_q;
    busy_d      = busy_q;
    done_tick_d = 1'b0;
    err_tick_d  = 1'b0;
    led_state_d = led_state_q;
    tx_wr_d     = 1'b0;
    tx_din_d    = tx_din_q;
    fwd_tick_d  = fwd;
    fwd_data_d  = fwd ? rx_data : fwd_data_q;
`ifdef KB_LED_AUTO_EN
    brk_d       = brk_q;
    shadow_d    = shadow_q;
    auto_pend_d = auto_pend_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (led_req) begin
          arg_d   = led_val;
          retry_d = '0;
          busy_d  = 1'b1;
          state_d = SEND_CMD;
        end
`ifdef KB_LED_AUTO_EN
        else if (auto_pend_q) begin
          arg_d       = shadow_q;
          retry_d     = '0;
          busy_d      = 1'b1;
          auto_pend_d = 1'b0;
          state_d     = SEND_CMD;
        end
`endif
      end
      SEND_CMD, SEND_ARG: begin
        if (tx_idle) begin
          tx_wr_d  = 1'b1;
          tx_din_d = (state_q == SEND_CMD) ? 8'hED : {5'b0, arg_q};
          timer_d  = '0;
          state_d  = (state_q == SEND_CMD) ? WAIT_ACK1 : WAIT_ACK2;
        end
      end
      WAIT_ACK1, WAIT_ACK2: begin
        if (timer_q != TMAX) timer_d = timer_q + TW'(1);
        if (rx_done_tick && is_ack) begin
          retry_d = '0;
          if (state_q == WAIT_ACK1) begin
            state_d = SEND_ARG;
          end else begin
            state_d     = DONE;
            done_tick_d = 1'b1;
            led_state_d = arg_q;
`ifdef KB_LED_AUTO_EN
            shadow_d    = arg_q;
`endif
          end
        end else if (rx_done_tick && is_rsd) begin
          if (retry_q < RW'(MAX_RETRY)) begin
            retry_d = retry_q + RW'(1);
            state_d = (state_q == WAIT_ACK1) ? SEND_CMD : SEND_ARG;
          end else begin
            state_d    = ERR;
            err_tick_d = 1'b1;
          end
        end else if (timer_q == TMAX) begin
          state_d    = ERR;
          err_tick_d = 1'b1;
        end
      end
      DONE, ERR: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

`ifdef KB_LED_AUTO_EN
    // 0xE0 prefix leaves the break flag untouched so E0 F0 xx still reads as a break
    if (fwd) begin
      if (rx_data == 8'hF0) begin
        brk_d = 1'b1;
      end else if (rx_data != 8'hE0) begin
        brk_d = 1'b0;
        if (!brk_q) begin
          case (rx_data)
            8'h58: begin shadow_d[2] = ~shadow_d[2]; auto_pend_d = 1'b1; end
            8'h77: begin shadow_d[1] = ~shadow_d[1]; auto_pend_d = 1'b1; end
            8'h7E: begin shadow_d[0] = ~shadow_d[0]; auto_pend_d = 1'b1; end
            default: ;
          endcase
        end
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      arg_q       <= '0;
      retry_q     <= '0;
      timer_q     <= '0;
      busy_q      <= 1'b0;
      done_tick_q <= 1'b0;
      err_tick_q  <= 1'b0;
      led_state_q <= '0;
      tx_wr_q     <= 1'b0;
      tx_din_q    <= '0;
      fwd_tick_q  <= 1'b0;
      fwd_data_q  <= '0;
`ifdef KB_LED_AUTO_EN
      brk_q       <= 1'b0;
      shadow_q    <= '0;
      auto_pend_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      arg_q       <= arg_d;
      retry_q     <= retry_d;
      timer_q     <= timer_d;
      busy_q      <= busy_d;
      done_tick_q <= done_tick_d;
      err_tick_q  <= err_tick_d;
      led_state_q <= led_state_d;
      tx_wr_q     <= tx_wr_d;
      tx_din_q    <= tx_din_d;
      fwd_tick_q  <= fwd_tick_d;
      fwd_data_q  <= fwd_data_d;
`ifdef KB_LED_AUTO_EN
      brk_q       <= brk_d;
      shadow_q    <= shadow_d;
      auto_pend_q <= auto_pend_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done_tick = done_tick_q;
  assign err_tick  = err_tick_q;
  assign led_state = led_state_q;
  assign tx_wr     = tx_wr_q;
  assign tx_din    = tx_din_q;
  assign fwd_tick  = fwd_tick_q;
  assign fwd_data  = fwd_data_q;
endmodule

// File: tb/tb_kb_led_ctrl.sv
// Scoreboard bench for kb_led_ctrl: a keyboard-side driver pushes expected tx/fwd/outcome events,
// a monitor pops and compares them whenever the DUT strobes an output.
module tb_kb_led_ctrl;
  localparam int TO = 40;
  localparam int MR = 3;

  logic       clk = 1'b0, rst = 1'b1;
  logic       led_req = 1'b0;
  logic [2:0] led_val = 3'b000;
  logic       busy, done_tick, err_tick;
  logic [2:0] led_state;
  logic       tx_idle = 1'b1, tx_wr;
  logic [7:0] tx_din;
  logic       rx_done_tick = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       fwd_tick;
  logic [7:0] fwd_data;

  kb_led_ctrl #(.TIMEOUT_CYC(TO), .MAX_RETRY(MR)) dut (
    .clk(clk), .rst(rst), .led_req(led_req), .led_val(led_val),
    .busy(busy), .done_tick(done_tick), .err_tick(err_tick), .led_state(led_state),
    .tx_idle(tx_idle), .tx_wr(tx_wr), .tx_din(tx_din),
    .rx_done_tick(rx_done_tick), .rx_data(rx_data),
    .fwd_tick(fwd_tick), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  typedef struct {int kind; logic [2:0] led;} out_t;  // kind: 0 done, 1 retry err, 2 timeout err
  logic [7:0] exp_tx[$];
  logic [7:0] exp_fwd[$];
  out_t       exp_out[$];
  logic [7:0] plan_q[$];   // directed keyboard replies; 8'h00 means stay silent
  logic [7:0] junk_q[$];   // directed non-ACK bytes injected while waiting
  int         errors = 0, checks = 0;
  longint     cyc = 0, last_tx_cyc = 0;
  logic [2:0] cur_led = 3'b000;
  bit         tx_rand = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event seen, required none / bound expired", name);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    tx_idle = tx_rand ? ($urandom_range(0, 4) != 0) : 1'b1;
  end

  // Monitor: compare every DUT strobe against the head of its queue
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (tx_wr) begin
        if (exp_tx.size() == 0) fail("tx_unexpected");
        else chk("tx_din", {24'b0, tx_din}, {24'b0, exp_tx.pop_front()});
        last_tx_cyc = cyc;
      end
      if (fwd_tick) begin
        if (exp_fwd.size() == 0) fail("fwd_unexpected");
        else chk("fwd_data", {24'b0, fwd_data}, {24'b0, exp_fwd.pop_front()});
      end
      if (done_tick || err_tick) begin
        if (exp_out.size() == 0) fail("outcome_unexpected");
        else begin
          out_t o;
          o = exp_out.pop_front();
          chk("outcome", {30'b0, done_tick, err_tick}, (o.kind == 0) ? 32'd2 : 32'd1);
          chk("led_state", {29'b0, led_state}, {29'b0, o.led});
          if (o.kind == 2) chk("timeout_latency", 32'(cyc - last_tx_cyc), TO);
        end
      end
    end
  end

  task automatic send_rx(input logic [7:0] b);
    @(negedge clk);
    rx_done_tick = 1'b1;
    rx_data = b;
    @(negedge clk);
    rx_done_tick = 1'b0;
  endtask

  task automatic wait_tx(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (tx_wr) begin ok = 1'b1; break; end
    end
    if (!ok) fail("tx_wait");
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < TO + 60; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    if (!ok) fail("busy_wait");
  endtask

  // Keyboard + reference model: the protocol rules decide each reply's outcome
  task automatic run_txn(input logic [2:0] v, input bit rnd);
    logic [7:0] junk_tbl[6] = '{8'h1C, 8'h32, 8'h21, 8'h45, 8'h5A, 8'h66};
    int phase = 0, retries = 0, x;
    bit fin = 1'b0, ok;
    logic [7:0] r, j;
    @(negedge clk);
    led_req = 1'b1;
    led_val = v;
    @(negedge clk);
    led_req = 1'b0;
    led_val = 3'($urandom);
    while (!fin) begin
      exp_tx.push_back(phase == 0 ? 8'hED : {5'b0, v});
      wait_tx(ok);
      if (!ok) break;
      if (plan_q.size() != 0) r = plan_q.pop_front();
      else begin
        x = $urandom_range(0, 19);
        r = (x < 12) ? 8'hFA : (x < 19) ? 8'hFE : 8'h00;
      end
      if (rnd) repeat ($urandom_range(0, 4)) @(negedge clk);
      if (junk_q.size() != 0 || (rnd && $urandom_range(0, 3) == 0)) begin
        j = (junk_q.size() != 0) ? junk_q.pop_front() : junk_tbl[$urandom_range(0, 5)];
        exp_fwd.push_back(j);
        send_rx(j);
      end
      if (rnd && $urandom_range(0, 5) == 0) begin
        @(negedge clk);
        led_req = 1'b1;
        led_val = 3'($urandom);
        @(negedge clk);
        led_req = 1'b0;
      end
      if (r == 8'h00) begin
        exp_out.push_back('{2, cur_led});
        fin = 1'b1;
      end else if (r == 8'hFA) begin
        if (phase == 1) begin
          cur_led = v;
          exp_out.push_back('{0, v});
          fin = 1'b1;
        end else begin
          phase = 1;
          retries = 0;
        end
        send_rx(r);
      end else begin
        if (retries < MR) retries++;
        else begin
          exp_out.push_back('{1, cur_led});
          fin = 1'b1;
        end
        send_rx(r);
      end
    end
    wait_idle();
  endtask

  initial begin
    bit ok;
    logic [7:0] idle_tbl[6] = '{8'hFA, 8'hFE, 8'hF0, 8'h1C, 8'h29, 8'h4B};
    logic [7:0] b;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {8'b0, busy, done_tick, err_tick, tx_wr, fwd_tick, tx_din, fwd_data, led_state}, 32'd0);
    rst = 1'b0;
    tx_rand = 1'b0;

    // Plain Set LEDs
    plan_q = '{8'hFA, 8'hFA};
    run_txn(3'b101, 1'b0);
    chk("led_after_t1", {29'b0, led_state}, 32'd5);
    chk("busy_after_t1", {31'b0, busy}, 32'd0);
    // Two resends then success, then resend exhaustion
    plan_q = '{8'hFE, 8'hFE, 8'hFA, 8'hFA};
    run_txn(3'b011, 1'b0);
    plan_q = '{8'hFE, 8'hFE, 8'hFE, 8'hFE};
    run_txn(3'b110, 1'b0);
    // Silence after 0xED
    plan_q = '{8'h00};
    run_txn(3'b111, 1'b0);
    // Scan byte interleaved with ACK wait
    plan_q = '{8'hFA, 8'hFA};
    junk_q = '{8'h1C};
    run_txn(3'b010, 1'b0);
    // Stray ACK and break prefix in IDLE are forwarded
    foreach (idle_tbl[i]) begin
      if (i < 4) begin
        b = (i == 3) ? 8'h1C : idle_tbl[i];
        if (i == 2) b = 8'hF0;
        exp_fwd.push_back(b);
        send_rx(b);
      end
    end
    repeat (2) @(negedge clk);

    tx_rand = 1'b1;
    for (int t = 0; t < 40; t++) begin
      run_txn(3'($urandom), 1'b1);
      if ($urandom_range(0, 2) == 0) begin
        b = idle_tbl[$urandom_range(0, 5)];
        exp_fwd.push_back(b);
        send_rx(b);
      end
    end

    // Reset while waiting for the argument ACK
    tx_rand = 1'b0;
    plan_q = '{8'hFA, 8'hFA};
    run_txn(3'b110, 1'b0);
    @(negedge clk);
    led_req = 1'b1;
    led_val = 3'b001;
    @(negedge clk);
    led_req = 1'b0;
    exp_tx.push_back(8'hED);
    wait_tx(ok);
    send_rx(8'hFA);
    exp_tx.push_back(8'h01);
    wait_tx(ok);
    repeat (2) @(negedge clk);
    chk("busy_before_rst", {31'b0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1 chk("async_rst_outputs", {8'b0, busy, done_tick, err_tick, tx_wr, fwd_tick, tx_din, fwd_data, led_state}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cur_led = 3'b000;
    repeat (TO + 20) @(negedge clk);
    chk("idle_after_rst", {28'b0, busy, led_state}, 32'd0);

`ifdef KB_LED_AUTO_EN
    // Caps make toggles shadow and auto-starts; F0 58 during the transaction is a break
    exp_fwd.push_back(8'h1C);
    send_rx(8'h1C);
    exp_fwd.push_back(8'h58);
    exp_tx.push_back(8'hED);
    send_rx(8'h58);
    wait_tx(ok);
    exp_fwd.push_back(8'hF0);
    send_rx(8'hF0);
    exp_fwd.push_back(8'h58);
    send_rx(8'h58);
    exp_tx.push_back(8'h04);
    send_rx(8'hFA);
    wait_tx(ok);
    exp_out.push_back('{0, 3'b100});
    send_rx(8'hFA);
    wait_idle();
    repeat (TO + 20) @(negedge clk);
    chk("auto_led_state", {29'b0, led_state}, 32'd4);
`endif

    repeat (5) @(negedge clk);
    chk("tx_queue_drained", exp_tx.size(), 32'd0);
    chk("fwd_queue_drained", exp_fwd.size(), 32'd0);
    chk("outcome_queue_drained", exp_out.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/kb_led_ctrl.md
Name: kb_led_ctrl

Overview:
- Host-side sequencer sitting between the PS/2 receive/transmit pair and the keyboard scan-code FIFO path.
- Runs the PS/2 "Set LEDs" transaction: command 0xED, ACK 0xFA, argument byte, ACK 0xFA.
- Handles 0xFE resend requests and response timeouts.
- Owns the received-byte stream: ACK/resend bytes belonging to a transaction are consumed; all other bytes are forwarded to the scan-code path unchanged.

Parameters:
- TIMEOUT_CYC, 2500000, clk cycles allowed from a transmitted byte until its response before the transaction aborts. Counter width is $clog2(TIMEOUT_CYC).
- MAX_RETRY, 3, number of 0xFE resends tolerated per byte before the transaction aborts.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- led_req  in  1  one-cycle request to send led_val
- led_val  in  3  {caps, num, scroll}; bit0 = scroll, bit1 = num, bit2 = caps
- busy  out  1  transaction in progress
- done_tick  out  1  one-cycle pulse on successful completion
- err_tick  out  1  one-cycle pulse on timeout or retry exhaustion
- led_state  out  3  last LED value acknowledged by the keyboard
- tx_idle  in  1  PS/2 transmitter ready
- tx_wr  out  1  one-cycle transmit strobe
- tx_din  out  8  byte to transmit, valid while tx_wr = 1
- rx_done_tick  in  1  received byte valid
- rx_data  in  8  received byte
- fwd_tick  out  1  forwarded-byte strobe to the scan-code path
- fwd_data  out  8  forwarded byte

Behaviour:
- Reset (asynchronous, active-high): state IDLE; busy, done_tick, err_tick, tx_wr, fwd_tick = 0; tx_din, fwd_data = 0x00; led_state = 3'b000; retry count and timer = 0.
- States: IDLE, SEND_CMD, WAIT_ACK1, SEND_ARG, WAIT_ACK2, DONE, ERR.
- IDLE:
  - led_req = 1 latches led_val into arg_reg and moves to SEND_CMD.
  - busy = 1 from the next cycle until the cycle in which DONE or ERR exits.
  - led_req while busy is ignored, with no queuing.
- SEND_CMD / SEND_ARG:
  - Wait for tx_idle = 1, then assert tx_wr for exactly one cycle with tx_din = 0xED (CMD) or {5'b0, arg_reg} (ARG).
  - On the same edge, clear the timer and go to the matching WAIT state.
- WAIT_ACKn:
  - Timer increments every cycle.
  - On rx_done_tick with rx_data = 0xFA: go to SEND_ARG (from WAIT_ACK1) or DONE (from WAIT_ACK2), and clear the retry count.
  - On rx_data = 0xFE: if retry count < MAX_RETRY, increment it and return to the same SEND state (same byte is resent); otherwise go to ERR.
  - Any other byte is forwarded and waiting continues; the timer is not cleared.
  - If the timer reaches TIMEOUT_CYC-1 without a response: go to ERR. If rx_done_tick arrives in that same cycle, the byte is evaluated first and the timeout is not taken.
- DONE: done_tick = 1 for one cycle; led_state <= arg_reg; return to IDLE.
- ERR: err_tick = 1 for one cycle; led_state unchanged; return to IDLE.
- Forwarding:
  - Registered, one-cycle latency: fwd_tick and fwd_data follow rx_done_tick by exactly one clk.
  - In IDLE, every byte is forwarded, including stray 0xFA/0xFE.
  - In SEND and WAIT states, only 0xFA/0xFE are consumed.
- Timer saturates and never wraps.
- Reset mid-transaction: immediate return to the reset state. A partially sent byte is the transmitter's concern. No done_tick or err_tick is issued.

Optional Feature:
- Macro: KB_LED_AUTO_EN.
- When defined:
  - The forwarded stream is decoded.
  - 0xF0 arms a break flag, which is cleared by the next non-0xE0 byte.
  - A make code (break flag clear) toggles a shadow register bit: 0x58 toggles caps (bit2), 0x77 toggles num (bit1), 0x7E toggles scroll (bit0). Each toggle sets auto_pend.
  - In IDLE, auto_pend with no led_req starts a transaction using the shadow value and clears auto_pend. An external led_req has priority; auto_pend stays set in that case.
  - After any DONE, the shadow is loaded from led_state.
- When undefined: no decode logic; led_state changes only through led_req transactions.

Test Plan:
1. led_req with led_val = 3'b101; tx_idle = 1; reply 0xFA after each transmitted byte. Required: tx_din sequence 0xED then 0x05; one done_tick; led_state = 3'b101; busy low afterwards; no fwd_tick.
2. Reply 0xFE twice to 0xED, then 0xFA, then 0xFA to the argument. Required: 0xED transmitted 3 times; done_tick asserted. Replying 0xFE four times instead gives err_tick and led_state unchanged.
3. After 0xED, no reply for TIMEOUT_CYC cycles. Required: err_tick exactly TIMEOUT_CYC cycles after the tx_wr edge; state returns to IDLE.
4. In WAIT_ACK1, inject 0x1C then 0xFA. Required: fwd_tick with fwd_data = 0x1C one cycle later; 0xFA not forwarded; transaction completes.
5. In IDLE, inject 0xFA and 0xF0. Required: both forwarded. Assert rst while in WAIT_ACK2: all outputs reach reset values asynchronously.
6. With KB_LED_AUTO_EN defined: inject 0x58, then 0xF0, 0x58. Required: exactly one transaction with argument 0x04; led_state = 3'b100.
